// File: rtl/scan_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_set_ctrl_pkg
// Description : Shared definitions for the scan/set controller: mode
//               encodings, field identifiers, time-field limits, digit count
//               and the digit-to-field map used by the blink logic.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_set_ctrl_pkg;

   // Operating mode; the encoding is visible on the mode output.
   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2,
      MODE_SET_SEC  = 2'd3
   } mode_e;

   // Time field a digit or a SET mode refers to.
   typedef enum logic [1:0] {
      FIELD_NONE = 2'd0,
      FIELD_HOUR = 2'd1,
      FIELD_MIN  = 2'd2,
      FIELD_SEC  = 2'd3
   } field_e;

   localparam logic [6:0] HOUR_MAX   = 7'd23;
   localparam logic [6:0] MINSEC_MAX = 7'd59;
   localparam logic [3:0] NUM_DIGITS = 4'd6;
   localparam logic [3:0] LAST_DIGIT = NUM_DIGITS - 4'd1;

   // Display digit order: 0,1 = minutes, 2,3 = hours, 4,5 = seconds.
   function automatic field_e digit_field(input logic [3:0] sel);
      field_e f;
      f = FIELD_NONE;
      case (sel)
         4'd0, 4'd1: f = FIELD_MIN;
         4'd2, 4'd3: f = FIELD_HOUR;
         4'd4, 4'd5: f = FIELD_SEC;
         default:    f = FIELD_NONE;
      endcase
      return f;
   endfunction

   // Field being edited in a given mode; RUN edits nothing.
   function automatic field_e mode_field(input mode_e m);
      field_e f;
      f = FIELD_NONE;
      case (m)
         MODE_SET_HOUR: f = FIELD_HOUR;
         MODE_SET_MIN:  f = FIELD_MIN;
         MODE_SET_SEC:  f = FIELD_SEC;
         default:       f = FIELD_NONE;
      endcase
      return f;
   endfunction

   // Increment with wrap to zero once the field maximum is reached.
   function automatic logic [6:0] wrap_inc(input logic [6:0] v,
                                           input logic [6:0] max);
      return (v >= max) ? 7'd0 : (v + 7'd1);
   endfunction

   // Out-of-range live values are replaced by zero when captured.
   function automatic logic [6:0] clamp_zero(input logic [6:0] v,
                                             input logic [6:0] max);
      return (v > max) ? 7'd0 : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/scan_set_ctrl_tick.sv
`default_nettype none
// ============================================================================
// Module      : tick_div
// Description : Free-running prescaler. Counts 0..DIV-1 and wraps; tick is
//               high during the last count, so each wrap edge is one step.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               tick - one-cycle step strobe
// Revision    : 1.0 - initial release
// ============================================================================
module tick_div #(
   parameter int DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] r_count;

   assign tick = (r_count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/scan_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scan_set_ctrl
// Description : Clock display scan and time-set controller. Scans six display
//               digits, lets the user edit hours/minutes/seconds in shadow
//               registers with blinking of the edited field, and writes the
//               edited time back to the time counter with a one-cycle load.
// Ports       : clk, rst                   - clock, async active-high reset
//               key_mode, key_inc          - debounced one-cycle key pulses
//               hour_in/min_in/sec_in      - live time from the counter
//               hour_disp/min_disp/sec_disp- values for the display block
//               selct, blank               - digit index 0..5 and its blank
//               load, hour_set/min_set/sec_set - write-back to the counter
//               mode                       - 0 RUN, 1 HOUR, 2 MIN, 3 SEC
// Revision    : 1.0 - initial release
// ============================================================================
module scan_set_ctrl
   import scan_set_ctrl_pkg::*;
#(
   parameter int SCAN_DIV  = 1000,
   parameter int BLINK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_inc,
   input  logic [6:0] hour_in,
   input  logic [6:0] min_in,
   input  logic [6:0] sec_in,
   output logic [6:0] hour_disp,
   output logic [6:0] min_disp,
   output logic [6:0] sec_disp,
   output logic [3:0] selct,
   output logic       blank,
   output logic       load,
   output logic [6:0] hour_set,
   output logic [6:0] min_set,
   output logic [6:0] sec_set,
   output logic [1:0] mode
);

   localparam logic [9:0] BLINK_LAST = 10'(BLINK_DIV - 1);

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   mode_e      r_state;
   mode_e      w_state_next;
   logic       w_capture;
   logic       w_commit;
   logic       w_inc_accept;

   logic       w_tick;
   logic [3:0] r_sel;
   logic [3:0] w_sel_next;

   logic [9:0] r_blink_cnt;
   logic [9:0] w_cnt_next;
   logic       r_blink_phase;
   logic       w_phase_next;
   logic       w_blink_clr;
   logic       r_blank;
   logic       w_blank_next;

   logic       r_load;
   logic [6:0] r_sh_hour;
   logic [6:0] r_sh_min;
   logic [6:0] r_sh_sec;

   // ------------------------------------------------------------------
   // Scan prescaler
   // ------------------------------------------------------------------
   tick_div #(
      .DIV (SCAN_DIV)
   ) u_tick_div (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // ------------------------------------------------------------------
   // Mode FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= MODE_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Mode FSM: next state and event decode. key_mode takes priority, so
   // an increment arriving in the same cycle is dropped.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_commit     = 1'b0;
      w_inc_accept = 1'b0;
      if (key_mode) begin
         case (r_state)
            MODE_RUN: begin
               w_state_next = MODE_SET_HOUR;
               w_capture    = 1'b1;
            end
            MODE_SET_HOUR: w_state_next = MODE_SET_MIN;
            MODE_SET_MIN:  w_state_next = MODE_SET_SEC;
            default: begin
               w_state_next = MODE_RUN;
               w_commit     = 1'b1;
            end
         endcase
      end else if (key_inc && (r_state != MODE_RUN)) begin
         w_inc_accept = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Shadow registers: captured on entry to editing, incremented per key
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_hour <= 7'd0;
         r_sh_min  <= 7'd0;
         r_sh_sec  <= 7'd0;
      end else if (w_capture) begin
         r_sh_hour <= clamp_zero(hour_in, HOUR_MAX);
         r_sh_min  <= clamp_zero(min_in, MINSEC_MAX);
         r_sh_sec  <= clamp_zero(sec_in, MINSEC_MAX);
      end else if (w_inc_accept) begin
         case (r_state)
            MODE_SET_HOUR: r_sh_hour <= wrap_inc(r_sh_hour, HOUR_MAX);
            MODE_SET_MIN:  r_sh_min  <= wrap_inc(r_sh_min, MINSEC_MAX);
            MODE_SET_SEC:  r_sh_sec  <= wrap_inc(r_sh_sec, MINSEC_MAX);
            default:       ;
         endcase
      end
   end

   // Load is raised for the single cycle following the SET_SEC -> RUN edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load <= 1'b0;
      end else begin
         r_load <= w_commit;
      end
   end

   // ------------------------------------------------------------------
   // Scan counter and blink phase (next-state logic)
   // ------------------------------------------------------------------
   assign w_blink_clr = key_mode | w_inc_accept;

   always_comb begin
      w_sel_next = r_sel;
      if (w_tick) begin
         w_sel_next = (r_sel >= LAST_DIGIT) ? 4'd0 : (r_sel + 4'd1);
      end
   end

   // A clear restarts the blink period even if a scan step lands on the
   // same edge, so the field is always shown solid right after a keypress.
   always_comb begin
      w_cnt_next   = r_blink_cnt;
      w_phase_next = r_blink_phase;
      if (w_blink_clr) begin
         w_cnt_next   = 10'd0;
         w_phase_next = 1'b0;
      end else if (w_tick) begin
         if (r_blink_cnt >= BLINK_LAST) begin
            w_cnt_next   = 10'd0;
            w_phase_next = ~r_blink_phase;
         end else begin
            w_cnt_next = r_blink_cnt + 10'd1;
         end
      end
   end

   // Blank is computed from next-state values so that the registered blank
   // always matches the registered selct and mode of the same cycle.
   always_comb begin
      w_blank_next = (w_state_next != MODE_RUN) && w_phase_next &&
                     (digit_field(w_sel_next) == mode_field(w_state_next));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel         <= 4'd0;
         r_blink_cnt   <= 10'd0;
         r_blink_phase <= 1'b0;
         r_blank       <= 1'b0;
      end else begin
         r_sel         <= w_sel_next;
         r_blink_cnt   <= w_cnt_next;
         r_blink_phase <= w_phase_next;
         r_blank       <= w_blank_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign mode      = r_state;
   assign selct     = r_sel;
   assign blank     = r_blank;
   assign load      = r_load;
   assign hour_set  = r_sh_hour;
   assign min_set   = r_sh_min;
   assign sec_set   = r_sh_sec;

   // Live time passes straight through while running.
   assign hour_disp = (r_state == MODE_RUN) ? hour_in : r_sh_hour;
   assign min_disp  = (r_state == MODE_RUN) ? min_in  : r_sh_min;
   assign sec_disp  = (r_state == MODE_RUN) ? sec_in  : r_sh_sec;

endmodule
`default_nettype wire

// File: tb/tb_scan_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_set_ctrl
// Description : Scoreboard bench for scan_set_ctrl with SCAN_DIV=4 and
//               BLINK_DIV=3. Stimulus pushes expected values into queues;
//               a monitor on the falling edge pops and compares them, and
//               checks every load pulse against the expected write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_set_ctrl;

   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 3;

   localparam int SIG_MODE  = 0;
   localparam int SIG_SEL   = 1;
   localparam int SIG_BLANK = 2;
   localparam int SIG_LOAD  = 3;
   localparam int SIG_HD    = 4;
   localparam int SIG_MD    = 5;
   localparam int SIG_SD    = 6;
   localparam int SIG_HS    = 7;
   localparam int SIG_MS    = 8;
   localparam int SIG_SS    = 9;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       key_mode = 1'b0;
   logic       key_inc  = 1'b0;
   logic [6:0] hour_in  = 7'd0;
   logic [6:0] min_in   = 7'd0;
   logic [6:0] sec_in   = 7'd0;
   logic [6:0] hour_disp, min_disp, sec_disp;
   logic [3:0] selct;
   logic       blank;
   logic       load;
   logic [6:0] hour_set, min_set, sec_set;
   logic [1:0] mode;

   scan_set_ctrl #(
      .SCAN_DIV  (SCAN_DIV),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_mode  (key_mode),
      .key_inc   (key_inc),
      .hour_in   (hour_in),
      .min_in    (min_in),
      .sec_in    (sec_in),
      .hour_disp (hour_disp),
      .min_disp  (min_disp),
      .sec_disp  (sec_disp),
      .selct     (selct),
      .blank     (blank),
      .load      (load),
      .hour_set  (hour_set),
      .min_set   (min_set),
      .sec_set   (sec_set),
      .mode      (mode)
   );

   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    sig;
      int    want;
   } chk_t;

   typedef struct {
      int h;
      int m;
      int s;
   } load_t;

   chk_t  chk_q[$];
   load_t load_q[$];
   int    checks    = 0;
   int    failures  = 0;
   bit    finishing = 1'b0;
   bit    drained   = 1'b0;

   // Bench-side model of time since reset release, last blink clear and mode.
   int cyc;
   int last_clr;
   int exp_mode;

   function automatic int probe(input int s);
      case (s)
         SIG_MODE:  return int'(mode);
         SIG_SEL:   return int'(selct);
         SIG_BLANK: return int'(blank);
         SIG_LOAD:  return int'(load);
         SIG_HD:    return int'(hour_disp);
         SIG_MD:    return int'(min_disp);
         SIG_SD:    return int'(sec_disp);
         SIG_HS:    return int'(hour_set);
         SIG_MS:    return int'(min_set);
         SIG_SS:    return int'(sec_set);
         default:   return -1;
      endcase
   endfunction

   task automatic exp_push(input string name, input int sig, input int want);
      chk_t c;
      c.name = name;
      c.sig  = sig;
      c.want = want;
      chk_q.push_back(c);
   endtask

   // Scan steps land on every SCAN_DIV-th rising edge after reset release.
   function automatic int model_sel();
      return (cyc / SCAN_DIV) % 6;
   endfunction

   function automatic int model_blank();
      int sel;
      int phase;
      bit hit;
      sel   = model_sel();
      phase = (((cyc / SCAN_DIV) - (last_clr / SCAN_DIV)) / BLINK_DIV) % 2;
      case (exp_mode)
         1:       hit = (sel == 2) || (sel == 3);
         2:       hit = (sel < 2);
         3:       hit = (sel >= 4);
         default: hit = 1'b0;
      endcase
      return (hit && (phase == 1)) ? 1 : 0;
   endfunction

   // One clock with the given key pulses; pushes mode/selct/blank expectations.
   task automatic cyc_step(input bit km, input bit ki);
      key_mode = km;
      key_inc  = ki;
      @(posedge clk);
      #1;
      key_mode = 1'b0;
      key_inc  = 1'b0;
      cyc++;
      if (km) begin
         exp_mode = (exp_mode + 1) % 4;
         last_clr = cyc;
      end else if (ki && (exp_mode != 0)) begin
         last_clr = cyc;
      end
      exp_push("mode", SIG_MODE, exp_mode);
      exp_push("selct", SIG_SEL, model_sel());
      exp_push("blank", SIG_BLANK, model_blank());
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      chk_t  c;
      load_t l;
      int    act;
      while (chk_q.size() > 0) begin
         c   = chk_q.pop_front();
         act = probe(c.sig);
         checks++;
         if (act != c.want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", c.name, act, c.want, $time);
         end
      end
      if (load === 1'b1) begin
         checks++;
         if (load_q.size() == 0) begin
            failures++;
            $display("FAIL load_unexpected: got load=1, want 0 (t=%0t)", $time);
         end else begin
            l = load_q.pop_front();
            if ((int'(hour_set) != l.h) || (int'(min_set) != l.m) || (int'(sec_set) != l.s)) begin
               failures++;
               $display("FAIL load_values: got %0d:%0d:%0d, want %0d:%0d:%0d",
                        hour_set, min_set, sec_set, l.h, l.m, l.s);
            end
         end
      end
      if (finishing && !drained) begin
         drained = 1'b1;
         checks++;
         if ((chk_q.size() != 0) || (load_q.size() != 0)) begin
            failures++;
            $display("FAIL drain: got %0d pending loads, want 0", load_q.size());
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      load_t ld;
      int    m;
      int    guard;

      cyc      = 0;
      last_clr = 0;
      exp_mode = 0;
      hour_in  = 7'd22;
      min_in   = 7'd30;
      sec_in   = 7'd45;
      rst      = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      exp_push("rst_mode", SIG_MODE, 0);
      exp_push("rst_selct", SIG_SEL, 0);
      exp_push("rst_blank", SIG_BLANK, 0);
      exp_push("rst_load", SIG_LOAD, 0);
      exp_push("rst_hour_set", SIG_HS, 0);
      exp_push("rst_min_set", SIG_MS, 0);
      exp_push("rst_sec_set", SIG_SS, 0);
      exp_push("rst_hour_disp", SIG_HD, 22);
      exp_push("rst_min_disp", SIG_MD, 30);
      exp_push("rst_sec_disp", SIG_SD, 45);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Scan: selct steps every 4 cycles, 0..5 then back to 0
      for (int i = 0; i < 28; i++) begin
         cyc_step(1'b0, 1'b0);
         if (cyc == 24) exp_push("scan_wrap", SIG_SEL, 0);
         if (cyc == 20) exp_push("scan_five", SIG_SEL, 5);
      end

      // Hour edit with wrap 22 -> 23 -> 0
      cyc_step(1'b1, 1'b0);
      exp_push("cap_hour", SIG_HD, 22);
      exp_push("cap_min", SIG_MD, 30);
      exp_push("cap_sec", SIG_SD, 45);
      hour_in = 7'd7;
      cyc_step(1'b0, 1'b1);
      exp_push("hour_inc1", SIG_HD, 23);
      cyc_step(1'b0, 1'b1);
      exp_push("hour_wrap", SIG_HD, 0);
      exp_push("hour_set_wrap", SIG_HS, 0);

      // Align so the SET_MIN blink window covers digits 0 and 1
      guard = 0;
      while (((((cyc + 1) / SCAN_DIV) % 6) != 2) && (guard < 30)) begin
         cyc_step(1'b0, 1'b0);
         guard++;
      end

      // Collision: mode wins, increment discarded
      cyc_step(1'b1, 1'b1);
      exp_push("coll_hour", SIG_HD, 0);
      exp_push("coll_hour_set", SIG_HS, 0);
      exp_push("coll_min", SIG_MD, 30);

      // Blink in SET_MIN
      for (int i = 0; i < 30; i++) cyc_step(1'b0, 1'b0);
      guard = 0;
      while ((model_blank() == 0) && (guard < 48)) begin
         cyc_step(1'b0, 1'b0);
         guard++;
      end
      cyc_step(1'b0, 1'b1);
      exp_push("blank_clr", SIG_BLANK, 0);
      exp_push("min_inc1", SIG_MD, 31);

      // Edit minutes on to 5 (through the 59 -> 0 wrap)
      m = 31;
      for (int i = 0; i < 34; i++) begin
         cyc_step(1'b0, 1'b1);
         m = (m == 59) ? 0 : m + 1;
         exp_push("min_inc", SIG_MD, m);
      end
      exp_push("min_final", SIG_MD, 5);

      // SET_SEC, one increment
      cyc_step(1'b1, 1'b0);
      exp_push("sec_enter", SIG_SD, 45);
      exp_push("min_set_hold", SIG_MS, 5);
      cyc_step(1'b0, 1'b1);
      exp_push("sec_inc", SIG_SD, 46);

      // Commit back to RUN
      ld.h = 0;
      ld.m = 5;
      ld.s = 46;
      load_q.push_back(ld);
      cyc_step(1'b1, 1'b0);
      exp_push("commit_load", SIG_LOAD, 1);
      exp_push("run_hour_disp", SIG_HD, 7);
      exp_push("run_min_disp", SIG_MD, 30);
      exp_push("run_sec_disp", SIG_SD, 45);
      cyc_step(1'b0, 1'b0);
      exp_push("load_drop", SIG_LOAD, 0);

      // key_inc ignored in RUN
      cyc_step(1'b0, 1'b1);
      exp_push("run_inc_hs", SIG_HS, 0);
      exp_push("run_inc_ms", SIG_MS, 5);
      exp_push("run_inc_ss", SIG_SS, 46);

      // Out-of-range capture is forced to 0
      hour_in = 7'd30;
      min_in  = 7'd60;
      sec_in  = 7'd59;
      cyc_step(1'b1, 1'b0);
      exp_push("oor_hour", SIG_HD, 0);
      exp_push("oor_min", SIG_MD, 0);
      exp_push("oor_sec", SIG_SD, 59);
      cyc_step(1'b1, 1'b0);
      cyc_step(1'b1, 1'b0);
      cyc_step(1'b0, 1'b1);
      exp_push("sec_wrap", SIG_SD, 0);

      // Asynchronous reset while in SET_SEC, between clock edges
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      exp_push("arst_mode", SIG_MODE, 0);
      exp_push("arst_selct", SIG_SEL, 0);
      exp_push("arst_blank", SIG_BLANK, 0);
      exp_push("arst_load", SIG_LOAD, 0);
      exp_push("arst_sec_set", SIG_SS, 0);
      exp_push("arst_hour_disp", SIG_HD, 30);
      exp_push("arst_sec_disp", SIG_SD, 59);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cyc      = 0;
      last_clr = 0;
      exp_mode = 0;
      hour_in  = 7'd12;
      min_in   = 7'd34;
      sec_in   = 7'd56;
      cyc_step(1'b0, 1'b0);
      exp_push("post_hour_disp", SIG_HD, 12);
      exp_push("post_min_disp", SIG_MD, 34);
      exp_push("post_sec_disp", SIG_SD, 56);
      for (int i = 0; i < 6; i++) cyc_step(1'b0, 1'b0);
      exp_push("post_load", SIG_LOAD, 0);

      repeat (2) @(posedge clk);
      finishing = 1'b1;
      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
